// File: rtl/align_pkg.sv
// rtl/align_pkg.sv - shared constants, state encoding and sizing helper for the aligner family
package align_pkg;

   localparam int DATA_BIT_DEF = 256;
   localparam int SEG_NUM_DEF  = 4;

   typedef enum logic [1:0] {
      ST_HOLD = 2'b01,
      ST_RUN  = 2'b10
   } feed_state_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/align_sync_fifo.sv
// rtl/align_sync_fifo.sv - small synchronous FIFO with flush, sized by DEPTH (power of 2)
module align_sync_fifo
   import align_pkg::*;
#(
   parameter int DATA_BIT = DATA_BIT_DEF,
   parameter int DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_BIT-1:0]   wr_data,
   input  logic                  rd_en,
   output logic [DATA_BIT-1:0]   rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_BIT-1:0] mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = wr_en && !full && !flush;
   assign do_pop  = rd_en && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/align_p2s_feeder.sv
// rtl/align_p2s_feeder.sv - paces buffered wide words into the p2s serializer, SEG_NUM cycles apart
module align_p2s_feeder
   import align_pkg::*;
#(
   parameter int DATA_BIT = DATA_BIT_DEF,
   parameter int SEG_NUM  = SEG_NUM_DEF,
   parameter int DEPTH    = 4,
   parameter int HOLDOFF  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_BIT-1:0]    idata,
   input  logic                   idata_valid,
   output logic                   idata_ready,
   input  logic                   flush,
   output logic [DATA_BIT-1:0]    odata,
   output logic                   odata_valid,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int GW = $clog2(SEG_NUM);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   feed_state_t         state;
   feed_state_t         state_nxt;
   logic [HW-1:0]       hold_cnt;
   logic [HW-1:0]       hold_cnt_nxt;
   logic [GW-1:0]       gap_cnt;
   logic [DATA_BIT-1:0] head;
   logic                full;
   logic                empty;
   logic                push;
   logic                issue;

   // Ready looks only at registered occupancy, never at a same-cycle pop.
   assign idata_ready = rst_n && !full && !flush;
   assign push        = idata_valid && idata_ready;
   assign issue       = (state == ST_RUN) && !empty && (gap_cnt == '0) && !flush;

   align_sync_fifo #(
      .DATA_BIT (DATA_BIT),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (push),
      .wr_data (idata),
      .rd_en   (issue),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_HOLD;
         hold_cnt <= HW'(HOLDOFF - 1);
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      unique case (state)
         ST_HOLD: begin
            if (hold_cnt == '0)
               state_nxt = ST_RUN;
            else
               hold_cnt_nxt = hold_cnt - 1'b1;
         end
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_HOLD;
      endcase
   end

   // Flush clears pacing but leaves odata holding its last issued word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         odata       <= '0;
         odata_valid <= 1'b0;
         gap_cnt     <= '0;
      end else if (flush) begin
         odata_valid <= 1'b0;
         gap_cnt     <= '0;
      end else begin
         odata_valid <= issue;
         if (issue) begin
            odata   <= head;
            gap_cnt <= GW'(SEG_NUM - 1);
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule
